// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, two write ports and a
// busy scoreboard for long-latency results. Define RF_BYPASS_EN to forward same-cycle writes to reads.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr0_en,
  input  logic [AW-1:0]             wr0_addr,
  input  logic [XLEN-1:0]           wr0_data,
  input  logic                      wr1_en,
  input  logic [AW-1:0]             wr1_addr,
  input  logic [XLEN-1:0]           wr1_data,
  input  logic                      iss_en,
  input  logic [AW-1:0]             iss_addr,
  input  logic [NRD*AW-1:0]         rd_addr,
  output logic [NRD*XLEN-1:0]       rd_data,
  output logic [NRD-1:0]            rd_busy,
  output logic [$clog2(NREG+1)-1:0] pend_cnt,
  output logic                      iss_err
);

  localparam int CW = $clog2(NREG + 1);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   pend_cnt_q, pend_cnt_d;
  logic            iss_err_q, iss_err_d;

  logic wr0_act, wr1_act, iss_act;
  logic same_iss_wr1, cnt_inc, cnt_dec;

  assign wr0_act      = wr0_en && (wr0_addr != '0);
  assign wr1_act      = wr1_en && (wr1_addr != '0);
  assign iss_act      = iss_en && (iss_addr != '0);
  assign same_iss_wr1 = iss_act && wr1_act && (iss_addr == wr1_addr);

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr0_act) mem_d[wr0_addr] = wr0_data;
    if (wr1_act) mem_d[wr1_addr] = wr1_data;
  end

  // A same-cycle issue re-marks the register after the clear, so it ends busy.
  always_comb begin
    busy_d = busy_q;
    if (wr1_act) busy_d[wr1_addr] = 1'b0;
    if (iss_act) busy_d[iss_addr] = 1'b1;

    cnt_inc    = iss_act && !busy_q[iss_addr];
    cnt_dec    = wr1_act && busy_q[wr1_addr] && !same_iss_wr1;
    pend_cnt_d = pend_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);

    iss_err_d = iss_err_q;
    if (iss_act && busy_q[iss_addr] && !same_iss_wr1) iss_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
      iss_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      iss_err_q  <= iss_err_d;
    end
  end

  assign pend_cnt = pend_cnt_q;
  assign iss_err  = iss_err_q;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rd_addr[gi*AW +: AW];
`ifdef RF_BYPASS_EN
      // Forwarding is gated by rst so reads stay zero while reset is held.
      logic hit0, hit1;
      assign hit0 = !rst && wr0_act && (wr0_addr == addr);
      assign hit1 = !rst && wr1_act && (wr1_addr == addr);

      always_comb begin
        if (addr == '0) begin
          rd_data[gi*XLEN +: XLEN] = '0;
          rd_busy[gi]              = 1'b0;
        end else begin
          if (hit1)      rd_data[gi*XLEN +: XLEN] = wr1_data;
          else if (hit0) rd_data[gi*XLEN +: XLEN] = wr0_data;
          else           rd_data[gi*XLEN +: XLEN] = mem_q[addr];
          if (hit1 && !(iss_act && iss_addr == addr)) rd_busy[gi] = 1'b0;
          else                                         rd_busy[gi] = busy_q[addr];
        end
      end
`else
      always_comb begin
        if (addr == '0) begin
          rd_data[gi*XLEN +: XLEN] = '0;
          rd_busy[gi]              = 1'b0;
        end else begin
          rd_data[gi*XLEN +: XLEN] = mem_q[addr];
          rd_busy[gi]              = busy_q[addr];
        end
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: writes, collisions, scoreboard, bypass and async reset.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr0_en, wr1_en, iss_en;
  logic [4:0]  wr0_addr, wr1_addr, iss_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  pend_cnt;
  logic        iss_err;

  int checks = 0;
  int errors = 0;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .pend_cnt(pend_cnt), .iss_err(iss_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance past one posedge, then drop all enables.
  task automatic cyc();
    @(posedge clk);
    #1;
    wr0_en = 1'b0;
    wr1_en = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic rd_chk(input int port, input logic [4:0] a, input string tag,
                        input logic [31:0] exp_data, input logic exp_busy);
    rd_addr[port*5 +: 5] = a;
    #1;
    check({tag, ".data"}, rd_data[port*32 +: 32], exp_data);
    check({tag, ".busy"}, {31'd0, rd_busy[port]}, {31'd0, exp_busy});
  endtask

  initial begin
    rst = 1'b1;
    wr0_en = 1'b0; wr1_en = 1'b0; iss_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0; iss_addr = '0;
    wr0_data = '0; wr1_data = '0; rd_addr = '0;

    // Writes during reset are ignored, even through a clock edge.
    #2;
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h1234_5678;
    rd_chk(0, 5'd5, "rst_rd_x5", 32'h0, 1'b0);
    @(posedge clk); #1;
    rd_chk(0, 5'd5, "rst_after_edge_x5", 32'h0, 1'b0);
    check("rst_pend", {26'd0, pend_cnt}, 32'd0);
    check("rst_err", {31'd0, iss_err}, 32'd0);
    wr0_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd_addr[4:0] = a[4:0];
      #1;
      check($sformatf("sweep_x%0d", a), rd_data[31:0], 32'h0);
    end
    check("sweep_pend", {26'd0, pend_cnt}, 32'd0);

    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
    rd_chk(0, 5'd5, "x5_same_cycle", BYP ? 32'hDEAD_BEEF : 32'h0, 1'b0);
    cyc();
    rd_chk(0, 5'd5, "x5_after", 32'hDEAD_BEEF, 1'b0);

    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF_FFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    rd_chk(1, 5'd0, "x0_same_cycle", 32'h0, 1'b0);
    cyc();
    rd_chk(1, 5'd0, "x0_after", 32'h0, 1'b0);
    check("x0_pend", {26'd0, pend_cnt}, 32'd0);

    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1111_1111;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2222_2222;
    rd_chk(0, 5'd7, "x7_collide_same", BYP ? 32'h2222_2222 : 32'h0, 1'b0);
    cyc();
    rd_chk(0, 5'd7, "x7_collide", 32'h2222_2222, 1'b0);

    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'hB;
    cyc();
    rd_chk(0, 5'd3, "x3_dual", 32'hA, 1'b0);
    rd_chk(1, 5'd4, "x4_dual", 32'hB, 1'b0);

    // Scoreboard sequence.
    iss_en = 1'b1; iss_addr = 5'd9;
    cyc();
    rd_chk(0, 5'd9, "iss_x9", 32'h0, 1'b1);
    check("pend_1", {26'd0, pend_cnt}, 32'd1);
    iss_en = 1'b1; iss_addr = 5'd10;
    cyc();
    rd_chk(1, 5'd10, "iss_x10", 32'h0, 1'b1);
    check("pend_2", {26'd0, pend_cnt}, 32'd2);
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h55;
    rd_chk(0, 5'd9, "wr1_x9_same", BYP ? 32'h55 : 32'h0, BYP ? 1'b0 : 1'b1);
    cyc();
    rd_chk(0, 5'd9, "wr1_x9_after", 32'h55, 1'b0);
    check("pend_after_wr1", {26'd0, pend_cnt}, 32'd1);

    iss_en = 1'b1; iss_addr = 5'd9;
    cyc();
    check("pend_reiss_x9", {26'd0, pend_cnt}, 32'd2);
    iss_en = 1'b1; iss_addr = 5'd9;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h66;
    rd_chk(0, 5'd9, "iss_wr1_x9_same", BYP ? 32'h66 : 32'h55, 1'b1);
    cyc();
    rd_chk(0, 5'd9, "iss_wr1_x9", 32'h66, 1'b1);
    check("pend_iss_wr1", {26'd0, pend_cnt}, 32'd2);
    check("err_iss_wr1", {31'd0, iss_err}, 32'd0);

    iss_en = 1'b1; iss_addr = 5'd10;
    cyc();
    check("err_busy_iss", {31'd0, iss_err}, 32'd1);
    check("pend_busy_iss", {26'd0, pend_cnt}, 32'd2);
    wr1_en = 1'b1; wr1_addr = 5'd10; wr1_data = 32'h77;
    cyc();
    check("pend_clr_x10", {26'd0, pend_cnt}, 32'd1);
    check("err_sticky1", {31'd0, iss_err}, 32'd1);
    wr1_en = 1'b1; wr1_addr = 5'd11; wr1_data = 32'h88;
    cyc();
    rd_chk(1, 5'd11, "wr1_nonbusy_x11", 32'h88, 1'b0);
    check("pend_nonbusy", {26'd0, pend_cnt}, 32'd1);
    check("err_sticky2", {31'd0, iss_err}, 32'd1);

    // Bypass / no-bypass read-during-write.
    wr1_en = 1'b1; wr1_addr = 5'd12; wr1_data = 32'hCAFE_0000;
    rd_chk(0, 5'd12, "byp_x12_same", BYP ? 32'hCAFE_0000 : 32'h0, 1'b0);
    cyc();
    rd_chk(0, 5'd12, "byp_x12_next", 32'hCAFE_0000, 1'b0);
    wr0_en = 1'b1; wr0_addr = 5'd13; wr0_data = 32'h1;
    wr1_en = 1'b1; wr1_addr = 5'd13; wr1_data = 32'h2;
    rd_chk(1, 5'd13, "byp_x13_both", BYP ? 32'h2 : 32'h0, 1'b0);
    cyc();
    rd_chk(1, 5'd13, "x13_after", 32'h2, 1'b0);

    iss_en = 1'b1; iss_addr = 5'd10;
    cyc();
    iss_en = 1'b1; iss_addr = 5'd14;
    cyc();
    check("pend_3", {26'd0, pend_cnt}, 32'd3);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("async_pend", {26'd0, pend_cnt}, 32'd0);
    check("async_err", {31'd0, iss_err}, 32'd0);
    rd_chk(0, 5'd9, "async_x9", 32'h0, 1'b0);
    rd_chk(1, 5'd12, "async_x12", 32'h0, 1'b0);
    rd_chk(0, 5'd14, "async_x14", 32'h0, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h0000_ABCD;
    cyc();
    rd_chk(0, 5'd5, "first_wr_after_rst", 32'h0000_ABCD, 1'b0);
    check("err_after_rst", {31'd0, iss_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
